// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module     : cpu_pkg
// Description: Shared arbiter FSM encodings, port indices and default widths.
// Revision   : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int PORT_CPU  = 0;
    localparam int PORT_PROG = 1;

    localparam int DEF_REGISTER_WIDTH       = 4;
    localparam int DEF_MEMORY_ADDRESS_WIDTH = 4;
    localparam int DEF_MAX_WAIT             = 7;
    localparam int DEF_AGE_BITWIDTH         = 3;

endpackage
`default_nettype wire

// File: rtl/arb_age_counter.sv
`default_nettype none
// ============================================================================
// Module     : arb_age_counter
// Description: Saturating CPU wait counter; clear has priority over increment.
// Revision   : 1.0 - initial release
// ============================================================================
module arb_age_counter
    import cpu_pkg::*;
#(
    parameter int WIDTH    = DEF_AGE_BITWIDTH,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_incr,
    output logic o_at_max
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_WAIT);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_incr && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_max = (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : mem_arbiter
// Description: Two-port (CPU / programmer) arbiter in front of a single-port
//              memory; programmer priority with CPU aging. Optional burst lock
//              enabled by defining MEM_ARB_LOCK_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int REGISTER_WIDTH       = DEF_REGISTER_WIDTH,
    parameter int MEMORY_ADDRESS_WIDTH = DEF_MEMORY_ADDRESS_WIDTH,
    parameter int MAX_WAIT             = DEF_MAX_WAIT,
    parameter int AGE_BITWIDTH         = DEF_AGE_BITWIDTH
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic [1:0]                        req_i,
    input  logic [1:0]                        we_i,
    input  logic [2*MEMORY_ADDRESS_WIDTH-1:0] addr_i,
    input  logic [2*REGISTER_WIDTH-1:0]       wdata_i,
    input  logic                              lock_i,
    output logic [1:0]                        gnt_o,
    output logic [1:0]                        rvalid_o,
    output logic [REGISTER_WIDTH-1:0]         rdata_o,
    output logic                              mem_read_en_o,
    output logic                              mem_write_en_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0]   mem_addr_o,
    output logic [REGISTER_WIDTH-1:0]         mem_wdata_o,
    input  logic [REGISTER_WIDTH-1:0]         mem_rdata_i
);

    localparam int MAW = MEMORY_ADDRESS_WIDTH;
    localparam int RW  = REGISTER_WIDTH;

    arb_state_t        r_state;
    logic              r_owner;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rvalid;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [MAW-1:0]    r_mem_addr;
    logic [RW-1:0]     r_mem_wdata;

    logic              w_lock_active;
    logic              w_age_at_max;
    logic              w_grant_valid;
    logic              w_sel_cpu;
    logic              w_winner;
    logic              w_sel_we;
    logic [MAW-1:0]    w_sel_addr;
    logic [RW-1:0]     w_sel_wdata;
    logic              w_idle;
    logic              w_age_clear;
    logic              w_age_incr;

    // While locked only the programmer can win; the CPU waits even when aged out.
    assign w_idle        = (r_state == IDLE);
    assign w_grant_valid = w_lock_active ? req_i[PORT_PROG] : (|req_i);
    assign w_sel_cpu     = !w_lock_active && req_i[PORT_CPU]
                           && (!req_i[PORT_PROG] || w_age_at_max);
    assign w_winner      = w_sel_cpu ? 1'(PORT_CPU) : 1'(PORT_PROG);
    assign w_sel_we      = w_sel_cpu ? we_i[PORT_CPU] : we_i[PORT_PROG];
    assign w_sel_addr    = w_sel_cpu ? addr_i[0 +: MAW] : addr_i[MAW +: MAW];
    assign w_sel_wdata   = w_sel_cpu ? wdata_i[0 +: RW] : wdata_i[RW +: RW];

    assign w_age_clear = !req_i[PORT_CPU] || (w_idle && w_grant_valid && w_sel_cpu);
    assign w_age_incr  = w_idle && req_i[PORT_CPU] && w_grant_valid && !w_sel_cpu;

    arb_age_counter #(
        .WIDTH    (AGE_BITWIDTH),
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk      (clk_i),
        .rst_n    (reset_ni),
        .i_clear  (w_age_clear),
        .i_incr   (w_age_incr),
        .o_at_max (w_age_at_max)
    );

`ifdef MEM_ARB_LOCK_EN
    logic r_locked;

    assign w_lock_active = r_locked & lock_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_locked <= 1'b0;
        end else if (w_idle) begin
            if (w_grant_valid) begin
                r_locked <= !w_sel_cpu && lock_i;
            end else begin
                r_locked <= r_locked && lock_i;
            end
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = lock_i;
    assign w_lock_active = 1'b0;
`endif

    // Outputs are registered one edge ahead so they line up with ISSUE/RESP.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner           <= w_winner;
                        r_gnt[w_winner]   <= 1'b1;
                        r_mem_re          <= !w_sel_we;
                        r_mem_we          <= w_sel_we;
                        r_mem_addr        <= w_sel_addr;
                        r_mem_wdata       <= w_sel_wdata;
                        r_state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_rvalid[r_owner] <= r_mem_re;
                    r_state           <= r_mem_re ? RESP : IDLE;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o          = r_gnt;
    assign rvalid_o       = r_rvalid;
    assign rdata_o        = (|r_rvalid) ? mem_rdata_i : '0;
    assign mem_read_en_o  = r_mem_re;
    assign mem_write_en_o = r_mem_we;
    assign mem_addr_o     = r_mem_addr;
    assign mem_wdata_o    = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_mem_arbiter
// Description: Self-checking bench for mem_arbiter with a transaction-timeline
//              reference model and a behavioural memory.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int RW   = 4;
    localparam int MAW  = 4;
    localparam int MAXW = 7;

    logic               clk = 1'b0;
    logic               reset_ni;
    logic [1:0]         req;
    logic [1:0]         we;
    logic [2*MAW-1:0]   addr;
    logic [2*RW-1:0]    wdata;
    logic               lk;
    logic [1:0]         gnt_o;
    logic [1:0]         rvalid_o;
    logic [RW-1:0]      rdata_o;
    logic               mem_read_en_o;
    logic               mem_write_en_o;
    logic [MAW-1:0]     mem_addr_o;
    logic [RW-1:0]      mem_wdata_o;
    logic [RW-1:0]      env_rdata;

    logic [RW-1:0]      env_mem [2**MAW];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .req_i          (req),
        .we_i           (we),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .lock_i         (lk),
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .mem_read_en_o  (mem_read_en_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (env_rdata)
    );

    // Synchronous-read memory; contents restart at ~address on every reset.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < 2**MAW; i++) env_mem[i] <= ~RW'(i);
            env_rdata <= '0;
        end else begin
            if (mem_write_en_o) env_mem[mem_addr_o] <= mem_wdata_o;
            if (mem_read_en_o)  env_rdata <= env_mem[mem_addr_o];
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: arbitration timeline in whole transactions.
    logic [RW-1:0]  sh_mem [2**MAW];
    int             busy;
    int             age;
    bit             m_locked;
    bit             rd_pending;
    int             rd_port;
    logic [MAW-1:0] rd_addr;
    logic [1:0]     e_gnt, e_rv;
    logic [RW-1:0]  e_rd, e_wd;
    logic           e_re, e_we;
    logic [MAW-1:0] e_addr;
    bit             hold_prog;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2**MAW; i++) sh_mem[i] = ~RW'(i);
        busy = 0; age = 0; m_locked = 0; rd_pending = 0; rd_port = 0; rd_addr = '0;
        e_gnt = '0; e_rv = '0; e_rd = '0; e_wd = '0; e_re = 0; e_we = 0; e_addr = '0;
    endtask

    task automatic model_step();
        bit lock_eff;
        int win;
        e_gnt = '0; e_rv = '0; e_rd = '0; e_wd = '0; e_re = 0; e_we = 0; e_addr = '0;
        if (rd_pending) begin
            e_rv[rd_port] = 1'b1;
            e_rd = sh_mem[rd_addr];
            rd_pending = 0;
        end
        if (busy > 0) begin
            busy--;
            if (!req[0]) age = 0;
        end else begin
`ifdef MEM_ARB_LOCK_EN
            lock_eff = m_locked && lk;
`else
            lock_eff = 0;
`endif
            win = -1;
            if (!lock_eff && req[0] && (!req[1] || age == MAXW)) win = 0;
            else if (req[1]) win = 1;
            if (!req[0] || win == 0) age = 0;
            else if (win == 1 && age < MAXW) age++;
`ifdef MEM_ARB_LOCK_EN
            if (win >= 0) m_locked = (win == 1) && lk;
            else m_locked = m_locked && lk;
`endif
            if (win >= 0) begin
                e_gnt[win] = 1'b1;
                e_we   = we[win];
                e_re   = !we[win];
                e_addr = addr[win*MAW +: MAW];
                e_wd   = wdata[win*RW +: RW];
                if (we[win]) begin
                    sh_mem[e_addr] = e_wd;
                    busy = 1;
                end else begin
                    rd_pending = 1; rd_port = win; rd_addr = e_addr;
                    busy = 2;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(gnt_o), 32'(e_gnt));
        chk("rvalid", 32'(rvalid_o), 32'(e_rv));
        chk("mem_re", 32'(mem_read_en_o), 32'(e_re));
        chk("mem_we", 32'(mem_write_en_o), 32'(e_we));
        chk("mem_addr", 32'(mem_addr_o), 32'(e_addr));
        if (!e_re) chk("mem_wdata", 32'(mem_wdata_o), 32'(e_wd));
        if (e_rv != 2'b00) chk("rdata", 32'(rdata_o), 32'(e_rd));
    endtask

    // One clock: model decides at the edge, DUT sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (gnt_o[0]) req[0] = 1'b0;
        if (gnt_o[1] && !hold_prog) req[1] = 1'b0;
    endtask

    task automatic new_req(input int p, input logic w, input logic [MAW-1:0] a, input logic [RW-1:0] d);
        req[p] = 1'b1;
        we[p]  = w;
        addr[p*MAW +: MAW] = a;
        wdata[p*RW +: RW]  = d;
    endtask

    initial begin
        int  n_prog;
        bit  cpu_seen;
        reset_ni = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; lk = 1'b0; hold_prog = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset_ni = 1'b1;

        // CPU read of address 5 with programmer idle.
        new_req(0, 1'b0, 4'd5, 4'd0);
        step();
        chk("t1_gnt", 32'(gnt_o), 32'h1);
        step();
        chk("t1_rvalid", 32'(rvalid_o), 32'h1);
        chk("t1_rdata", 32'(rdata_o), 32'hA);
        step();

        // Simultaneous requests: programmer write wins, CPU then reads it back.
        new_req(0, 1'b0, 4'd3, 4'd0);
        new_req(1, 1'b1, 4'd3, 4'h6);
        step();
        chk("t2_prog_first", 32'(gnt_o), 32'h2);
        cpu_seen = 0;
        for (int i = 0; i < 10 && !rvalid_o[0]; i++) step();
        chk("t2_cpu_rvalid", 32'(rvalid_o), 32'h1);
        chk("t2_cpu_rdata", 32'(rdata_o), 32'h6);
        step();

        // Continuous programmer traffic: CPU wins once aged out.
        hold_prog = 1;
        new_req(1, 1'b1, 4'd9, 4'h3);
        new_req(0, 1'b0, 4'd1, 4'd0);
        n_prog = 0; cpu_seen = 0;
        for (int i = 0; i < 40 && !cpu_seen; i++) begin
            step();
            if (gnt_o[1]) n_prog++;
            if (gnt_o[0]) cpu_seen = 1;
        end
        chk("t3_cpu_granted", 32'(cpu_seen), 32'h1);
        chk("t3_prog_grants_before_cpu", 32'(n_prog), 32'd7);
        step();
        step();
        new_req(0, 1'b0, 4'd2, 4'd0);
        for (int i = 0; i < 10 && gnt_o == 2'b00; i++) step();
        chk("t3_age_cleared_prog_wins", 32'(gnt_o), 32'h2);
        hold_prog = 0;
        req[1] = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Reset during RESP of a CPU read.
        req = '0;
        new_req(0, 1'b0, 4'd7, 4'd0);
        step();
        step();
        chk("t4_in_resp", 32'(rvalid_o), 32'h1);
        reset_ni = 1'b0;
        req = '0;
        model_reset();
        #1;
        check_all();
        chk("t4_async_clear", 32'({gnt_o, rvalid_o, mem_read_en_o, mem_write_en_o}), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_no_rvalid", 32'(rvalid_o), 32'h0);
        end

        // Programmer stream with lock asserted plus a waiting CPU.
        lk = 1'b1;
        hold_prog = 1;
        new_req(1, 1'b1, 4'd4, 4'h5);
        new_req(0, 1'b0, 4'd4, 4'd0);
        n_prog = 0; cpu_seen = 0;
        for (int i = 0; i < 40 && !cpu_seen; i++) begin
            step();
            if (gnt_o[1]) n_prog++;
            if (gnt_o[0]) cpu_seen = 1;
        end
`ifdef MEM_ARB_LOCK_EN
        chk("t5_cpu_blocked_by_lock", 32'(cpu_seen), 32'h0);
        lk = 1'b0;
        for (int i = 0; i < 10 && !cpu_seen; i++) begin
            step();
            if (gnt_o[0]) cpu_seen = 1;
        end
        chk("t5_cpu_after_unlock", 32'(cpu_seen), 32'h1);
`else
        chk("t5_cpu_granted", 32'(cpu_seen), 32'h1);
        chk("t5_prog_grants_before_cpu", 32'(n_prog), 32'd7);
`endif
        lk = 1'b0;
        hold_prog = 0;
        req[1] = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // CPU request withdrawn before any edge samples it.
        req = '0;
        step();
        new_req(0, 1'b0, 4'd6, 4'd0);
        @(negedge clk);
        req[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_quiet", 32'({gnt_o, mem_read_en_o, mem_write_en_o}), 32'h0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (!req[p] && $urandom_range(0, 2) == 0)
                    new_req(p, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
            end
        end
        req = '0;
        for (int i = 0; i < 6; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
